// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DataMemory arbiter: IO address map and the
// encoding of the read-return tag.
package dmem_arbiter_pkg;

  localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

  // Everything at or above this address is memory-mapped IO.
  localparam logic [31:0] IO_BASE   = ADDR_HEX;

  // Owner of the read data arriving from DataMemory in the current cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_P0   = 2'd1,
    TAG_P1   = 2'd2
  } rd_tag_e;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational access filter for one requester: flags misaligned accesses
// and, when enabled, writes into the IO region.
module dmem_access_check #(
  parameter int                DBITS    = 32,
  parameter logic [DBITS-1:0]  IO_BASE  = dmem_arbiter_pkg::IO_BASE,
  parameter bit                BLOCK_IO_WRITE = 1'b0
) (
  input  logic             we,
  input  logic [DBITS-1:0] addr,
  output logic             misaligned,
  output logic             io_write,
  output logic             reject
);
  import dmem_arbiter_pkg::*;

  always_comb begin
    misaligned = ~is_word_aligned(addr[1:0]);
    io_write   = BLOCK_IO_WRITE && we && (addr >= IO_BASE);
    reject     = misaligned | io_write;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single DataMemory port. CPU (port 0) has
// priority; a starvation counter guarantees the loader (port 1) progresses.
module dmem_arbiter #(
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] IO_BASE    = dmem_arbiter_pkg::IO_BASE,
  parameter int               MAX_STREAK = 4,
  parameter int               CNT_BITS   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [DBITS-1:0] p0_addr,
  input  logic [DBITS-1:0] p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [DBITS-1:0] p0_rdata,
  output logic             p0_err,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [DBITS-1:0] p1_addr,
  input  logic [DBITS-1:0] p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [DBITS-1:0] p1_rdata,
  output logic             p1_err,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);
  import dmem_arbiter_pkg::*;

  localparam logic [CNT_BITS-1:0] STREAK_LIMIT = CNT_BITS'(MAX_STREAK);

  // Handshake: a transfer happens at the rising edge where req & gnt; gnt is
  // combinational from req and registered state, and req must be held until
  // granted. Responses (rvalid/err) appear the cycle after the transfer.

  logic [CNT_BITS-1:0] starve_cnt, starve_cnt_nxt;
  rd_tag_e             rd_tag, rd_tag_nxt;
  logic                err0_q, err1_q;
  logic                err0_nxt, err1_nxt;

  logic                contended, p1_due;
  logic                gnt0, gnt1;
  logic                rej0, rej1;
  logic                misal0, misal1, iow0, iow1;
  logic                sel_we, sel_rej;
  logic [DBITS-1:0]    sel_addr, sel_wdata;

  dmem_access_check #(
    .DBITS          (DBITS),
    .IO_BASE        (IO_BASE),
    .BLOCK_IO_WRITE (1'b0)
  ) u_check_p0 (
    .we         (p0_we),
    .addr       (p0_addr),
    .misaligned (misal0),
    .io_write   (iow0),
    .reject     (rej0)
  );

  dmem_access_check #(
    .DBITS          (DBITS),
    .IO_BASE        (IO_BASE),
    .BLOCK_IO_WRITE (1'b1)
  ) u_check_p1 (
    .we         (p1_we),
    .addr       (p1_addr),
    .misaligned (misal1),
    .io_write   (iow1),
    .reject     (rej1)
  );

  // Port 1 wins a contended cycle only once the CPU has used its full streak.
  always_comb begin
    contended = p0_req & p1_req;
    p1_due    = contended & (starve_cnt == STREAK_LIMIT);
    gnt0      = p0_req & ~p1_due;
    gnt1      = p1_req & ~gnt0;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_rej   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = p0_we;
      sel_rej   = rej0;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end else if (gnt1) begin
      sel_we    = p1_we;
      sel_rej   = rej1;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // Writes are suppressed outright while reset is asserted.
  assign mem_we    = reset_n & sel_we & ~sel_rej;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;

  always_comb begin
    starve_cnt_nxt = '0;
    if (contended && gnt0) begin
      if (starve_cnt == STREAK_LIMIT) begin
        starve_cnt_nxt = starve_cnt;
      end else begin
        starve_cnt_nxt = starve_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rd_tag_nxt = TAG_NONE;
    if (gnt0 && !p0_we && !rej0) begin
      rd_tag_nxt = TAG_P0;
    end else if (gnt1 && !p1_we && !rej1) begin
      rd_tag_nxt = TAG_P1;
    end
    err0_nxt = gnt0 & rej0;
    err1_nxt = gnt1 & rej1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      rd_tag     <= TAG_NONE;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      rd_tag     <= rd_tag_nxt;
      err0_q     <= err0_nxt;
      err1_q     <= err1_nxt;
    end
  end

  always_comb begin
    p0_rvalid = (rd_tag == TAG_P0);
    p1_rvalid = (rd_tag == TAG_P1);
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
    p0_err    = err0_q;
    p1_err    = err1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMemory + IO model and
// a response scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_err    (p0_err),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .p1_err    (p1_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // DataMemory with synchronous read and the IO registers.
  logic [31:0] ram [0:255];
  logic [31:0] hex, ledr, ledg;
  logic [3:0]  key;
  logic [9:0]  sw;

  function automatic logic [31:0] env_read(input logic [31:0] a);
    case (a)
      32'hF000_0000: return hex;
      32'hF000_0004: return ledr;
      32'hF000_0008: return ledg;
      32'hF000_0010: return {28'd0, key};
      32'hF000_0014: return {22'd0, sw};
      default:       return ram[a[9:2]];
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      hex       <= 32'd0;
      ledr      <= 32'd0;
      ledg      <= 32'd0;
      mem_rdata <= 32'd0;
      for (int i = 0; i < 256; i++) ram[i] <= 32'hC0DE_0000 | i;
    end else begin
      if (mem_we) begin
        case (mem_addr)
          32'hF000_0000: hex  <= mem_wdata;
          32'hF000_0004: ledr <= mem_wdata;
          32'hF000_0008: ledg <= mem_wdata;
          default: if (mem_addr < 32'hF000_0000) ram[mem_addr[9:2]] <= mem_wdata;
        endcase
      end
      mem_rdata <= env_read(mem_addr);
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [67:0] exp_q[$];
  logic [67:0] last_resp;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  function automatic logic [67:0] resp(input logic v0, input logic [31:0] d0,
                                       input logic v1, input logic [31:0] d1,
                                       input logic e0, input logic e1);
    return {v0, d0, v1, d1, e0, e1};
  endfunction

  function automatic logic [67:0] obs_resp();
    return {p0_rvalid, p0_rdata, p1_rvalid, p1_rdata, p0_err, p1_err};
  endfunction

  task automatic drive_idle();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  // One cycle: drive at negedge, check grant/memory pins and that the previous
  // response holds, then check this transfer's response after the edge.
  task automatic step(input string tag,
                      input logic r0, w0, input logic [31:0] a0, d0,
                      input logic r1, w1, input logic [31:0] a1, d1,
                      input logic [1:0] eg, input logic ew, input logic [67:0] er);
    logic [31:0] ea, ed;
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    exp_q.push_back(er);
    ea = eg[0] ? a0 : (eg[1] ? a1 : 32'd0);
    ed = eg[0] ? d0 : (eg[1] ? d1 : 32'd0);
    #1;
    chk({tag, " pins"}, {1'b0, p1_gnt, p0_gnt, mem_we, mem_addr, mem_wdata},
        {1'b0, eg, ew, ea, ed});
    chk({tag, " hold"}, obs_resp(), last_resp);
    @(posedge clk);
    #1;
    last_resp = exp_q.pop_front();
    chk({tag, " resp"}, obs_resp(), last_resp);
  endtask

  initial begin
    logic [9:0] pat;
    logic       g;
    reset_n = 0;
    drive_idle();
    key = 4'b0101;
    sw  = 10'b1010101010;
    last_resp = '0;
    p0_req = 1; p0_we = 1; p0_wdata = 32'h0000_DEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset resp", obs_resp(), 68'd0);
    chk("reset mem_we", {67'd0, mem_we}, 68'd0);
    @(negedge clk);
    reset_n = 1;
    drive_idle();

    step("idle", 0,0,0,0, 0,0,0,0, 2'b00, 0, 68'd0);

    // Reset arriving while a p0 read is in flight drops its data.
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    @(posedge clk);
    #1;
    chk("inflight read", obs_resp(), resp(1, 32'hC0DE_0000, 0, 0, 0, 0));
    reset_n = 0;
    p0_we = 1; p0_addr = 32'h8; p0_wdata = 32'h5555_5555;
    #1;
    chk("inflight reset resp", obs_resp(), 68'd0);
    chk("inflight reset mem_we", {67'd0, mem_we}, 68'd0);
    @(negedge clk);
    reset_n = 1;
    drive_idle();
    @(posedge clk);
    #1;
    chk("after reset no rvalid", obs_resp(), 68'd0);
    last_resp = '0;

    step("p0 hex write", 1,1,32'hF000_0000,32'h0000_0BAD, 0,0,0,0, 2'b01, 1, 68'd0);
    chk("hex shows bad", {36'd0, hex}, {36'd0, 32'h0000_0BAD});
    step("p1 ledr write", 0,0,0,0, 1,1,32'hF000_0004,32'hFF77_FF77, 2'b10, 0,
         resp(0, 0, 0, 0, 0, 1));
    chk("ledr unchanged", {36'd0, ledr}, 68'd0);
    step("p1 sw read", 0,0,0,0, 1,0,32'hF000_0014,0, 2'b10, 0,
         resp(0, 0, 1, 32'h0000_02AA, 0, 0));
    step("p0 misaligned", 1,0,32'h0000_0042,0, 0,0,0,0, 2'b01, 0,
         resp(0, 0, 0, 0, 1, 0));
    step("alt p0 key", 1,0,32'hF000_0010,0, 0,0,0,0, 2'b01, 0,
         resp(1, 32'h5, 0, 0, 0, 0));
    step("alt p1 sw", 0,0,0,0, 1,0,32'hF000_0014,0, 2'b10, 0,
         resp(0, 0, 1, 32'h0000_02AA, 0, 0));
    step("p0 ram read", 1,0,32'h4,0, 0,0,0,0, 2'b01, 0,
         resp(1, 32'hC0DE_0001, 0, 0, 0, 0));
    step("p0 write after read", 1,1,32'h8,32'h1234_5678, 0,0,0,0, 2'b01, 1, 68'd0);
    step("p0 readback", 1,0,32'h8,0, 0,0,0,0, 2'b01, 0,
         resp(1, 32'h1234_5678, 0, 0, 0, 0));
    step("p1 ram write", 0,0,0,0, 1,1,32'h10,32'hCAFE_F00D, 2'b10, 1, 68'd0);
    step("p1 readback", 0,0,0,0, 1,0,32'h10,0, 2'b10, 0,
         resp(0, 0, 1, 32'hCAFE_F00D, 0, 0));
    step("p1 misaligned write", 0,0,0,0, 1,1,32'h12,32'h1, 2'b10, 0,
         resp(0, 0, 0, 0, 0, 1));
    step("p1 io read key", 0,0,0,0, 1,0,32'hF000_0010,0, 2'b10, 0,
         resp(0, 0, 1, 32'h5, 0, 0));

    // Continuous contention: CPU gets four in a row, then the loader.
    pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      g = pat[i];
      step($sformatf("starve %0d", i), 1,0,32'h0,0, 1,0,32'h4,0,
           g ? 2'b10 : 2'b01, 0,
           g ? resp(0, 0, 1, 32'hC0DE_0001, 0, 0) : resp(1, 32'hC0DE_0000, 0, 0, 0, 0));
    end

    // A cycle with p1_req low restarts the streak.
    step("streak a0", 1,0,32'h0,0, 1,0,32'h4,0, 2'b01, 0, resp(1, 32'hC0DE_0000, 0, 0, 0, 0));
    step("streak a1", 1,0,32'h0,0, 1,0,32'h4,0, 2'b01, 0, resp(1, 32'hC0DE_0000, 0, 0, 0, 0));
    step("streak gap", 1,0,32'h0,0, 0,0,0,0, 2'b01, 0, resp(1, 32'hC0DE_0000, 0, 0, 0, 0));
    pat = 10'b00_0001_0000;
    for (int i = 0; i < 5; i++) begin
      g = pat[i];
      step($sformatf("restreak %0d", i), 1,0,32'h0,0, 1,0,32'h4,0,
           g ? 2'b10 : 2'b01, 0,
           g ? resp(0, 0, 1, 32'hC0DE_0001, 0, 0) : resp(1, 32'hC0DE_0000, 0, 0, 0, 0));
    end

    step("final idle", 0,0,0,0, 0,0,0,0, 2'b00, 0, 68'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
